// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for stream arbiters in the UART core.
package axis_arb_pkg;

   localparam int MAX_SRC  = 8;
   localparam int MAX_ID_W = 3;

   typedef enum logic {IDLE, LOCK} arb_state_t;

   // Round-robin pick: first set bit of req scanning upward from last+1 (mod n).
   // Returns last unchanged when nothing is requesting.
   function automatic logic [MAX_ID_W-1:0] rr_next(
      input logic [MAX_SRC-1:0]  req,
      input logic [MAX_ID_W-1:0] last,
      input int unsigned         n
   );
      logic [MAX_ID_W-1:0] res;
      int unsigned idx;
      res = last;
      for (int k = MAX_SRC; k >= 1; k--) begin
         if (k <= int'(n)) begin
            idx = (int'(last) + k) % n;
            if (req[idx]) res = MAX_ID_W'(idx);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin selector: rotate requests so last_gnt+1 sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module axis_rr_pick #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [ID_W-1:0]    last_gnt,
   output logic [ID_W-1:0]    pick,
   output logic               any
);

   logic [2*NUM_SRC-1:0] dbl;
   logic [NUM_SRC-1:0]   rot;
   logic [ID_W-1:0]      start;
   logic [ID_W-1:0]      offset;
   logic [ID_W:0]        sum;

   always_comb begin
      if (last_gnt == ID_W'(NUM_SRC - 1)) start = '0;
      else                                start = last_gnt + 1'b1;

      dbl = {req, req};
      rot = NUM_SRC'(dbl >> start);

      // Downward scan so the lowest rotated position wins.
      offset = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (rot[i]) offset = ID_W'(i);
      end

      sum = {1'b0, start} + {1'b0, offset};
      if (sum >= (ID_W+1)'(NUM_SRC)) sum = sum - (ID_W+1)'(NUM_SRC);
      pick = sum[ID_W-1:0];
      any  = |req;
   end

endmodule

// File: rtl/axis_tx_arbiter.sv
// Packet-level round-robin arbiter feeding a single registered AXI-Stream master;
// a grant is held from the first beat until the TLAST beat transfers.
module axis_tx_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 32,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_SRC-1:0]        s_tvalid,
   output logic [NUM_SRC-1:0]        s_tready,
   input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
   input  logic [NUM_SRC-1:0]        s_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic [DATA_W-1:0]         m_axis_tdata,
   output logic                      m_axis_tlast,
   output logic [ID_W-1:0]           m_axis_tid,
   output logic                      busy
);

   arb_state_t        state_reg, state_next;
   logic [ID_W-1:0]   gnt_reg, gnt_next;
   logic [ID_W-1:0]   last_gnt_reg, last_gnt_next;
   logic [ID_W-1:0]   pick;
   logic              any_req;
   logic              out_free;
   logic              accept;
   logic              sel_valid;
   logic              sel_last;
   logic [DATA_W-1:0] sel_data;

   logic              m_tvalid_reg;
   logic [DATA_W-1:0] m_tdata_reg;
   logic              m_tlast_reg;
   logic [ID_W-1:0]   m_tid_reg;

   axis_rr_pick #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_pick (
      .req      (s_tvalid),
      .last_gnt (last_gnt_reg),
      .pick     (pick),
      .any      (any_req)
   );

   assign out_free = !m_tvalid_reg || m_axis_tready;

   // Ready reaches only the granted source, and only when the output register can take a beat.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
      assign s_tready[gi] = (state_reg == LOCK) && (gnt_reg == ID_W'(gi)) && out_free;
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gnt_reg == ID_W'(i)) begin
            sel_valid = s_tvalid[i];
            sel_last  = s_tlast[i];
            sel_data  = s_tdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign accept = (state_reg == LOCK) && sel_valid && out_free;

   always_comb begin
      state_next    = state_reg;
      gnt_next      = gnt_reg;
      last_gnt_next = last_gnt_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               gnt_next      = pick;
               last_gnt_next = pick;
               state_next    = LOCK;
            end
         end
         LOCK: begin
            if (accept && sel_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         gnt_reg      <= '0;
         last_gnt_reg <= ID_W'(NUM_SRC - 1);
      end else begin
         state_reg    <= state_next;
         gnt_reg      <= gnt_next;
         last_gnt_reg <= last_gnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         m_tvalid_reg <= 1'b0;
         m_tdata_reg  <= '0;
         m_tlast_reg  <= 1'b0;
         m_tid_reg    <= '0;
      end else if (accept) begin
         m_tvalid_reg <= 1'b1;
         m_tdata_reg  <= sel_data;
         m_tlast_reg  <= sel_last;
         m_tid_reg    <= gnt_reg;
      end else if (out_free) begin
         m_tvalid_reg <= 1'b0;
      end
   end

   assign m_axis_tvalid = m_tvalid_reg;
   assign m_axis_tdata  = m_tdata_reg;
   assign m_axis_tlast  = m_tlast_reg;
   assign m_axis_tid    = m_tid_reg;
   assign busy          = (state_reg == LOCK);

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Self-checking bench for axis_tx_arbiter: directed scenarios plus randomized traffic
// against a behavioural packet-arbitration model.
module tb_axis_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    s_tvalid;
   logic [N-1:0]    s_tready;
   logic [N*DW-1:0] s_tdata;
   logic [N-1:0]    s_tlast;
   logic            m_tvalid;
   logic            m_tready;
   logic [DW-1:0]   m_tdata;
   logic            m_tlast;
   logic [IW-1:0]   m_tid;
   logic            busy;

   always #5 clk = ~clk;

   axis_tx_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ID_W(IW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_tvalid      (s_tvalid),
      .s_tready      (s_tready),
      .s_tdata       (s_tdata),
      .s_tlast       (s_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tlast  (m_tlast),
      .m_axis_tid    (m_tid),
      .busy          (busy)
   );

   int checks   = 0;
   int failures = 0;

   // Model: owner of the current packet (-1 = none), last served source, output beat.
   int            mg;
   int            ml;
   bit            mv;
   logic [DW-1:0] md;
   bit            mlst;
   int            mid;
   logic [N-1:0]  exp_rdy;
   logic [N-1:0]  hs;

   // Random source generators.
   int src_seq [N];
   int src_pos [N];
   int src_len [N];
   int tid_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mg = -1; ml = N - 1; mv = 0; md = '0; mlst = 0; mid = 0;
   endtask

   // One clock cycle: compare against the model, advance the model, cross the edge.
   task automatic step();
      bit free;
      int j;
      #1;
      free    = !mv || m_tready;
      exp_rdy = '0;
      if (mg >= 0 && free) exp_rdy[mg] = 1'b1;
      chk("s_tready", 64'(s_tready), 64'(exp_rdy));
      chk("m_tvalid", 64'(m_tvalid), 64'(mv));
      chk("busy", 64'(busy), 64'(mg >= 0));
      if (mv) begin
         chk("m_tdata", 64'(m_tdata), 64'(md));
         chk("m_tlast", 64'(m_tlast), 64'(mlst));
         chk("m_tid", 64'(m_tid), 64'(mid));
      end
      hs = reset_n ? (s_tvalid & exp_rdy) : '0;
      if (!reset_n) begin
         model_reset();
      end else if (mg < 0) begin
         for (int k = 1; k <= N; k++) begin
            j = (ml + k) % N;
            if (s_tvalid[j]) begin
               mg = j; ml = j;
               break;
            end
         end
         if (free) mv = 0;
      end else if (s_tvalid[mg] && free) begin
         mv = 1; md = s_tdata[mg*DW +: DW]; mlst = s_tlast[mg]; mid = mg;
         if (mlst) mg = -1;
      end else if (free) begin
         mv = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic put(input int i, input logic [DW-1:0] d, input bit l);
      s_tdata[i*DW +: DW] = d;
      s_tlast[i]          = l;
   endtask

   task automatic src_init(input int minlen, input int maxlen);
      for (int i = 0; i < N; i++) begin
         src_pos[i] = 0;
         src_len[i] = $urandom_range(minlen, maxlen);
      end
   endtask

   task automatic drive_sources(input int prob);
      for (int i = 0; i < N; i++) begin
         s_tvalid[i] = ($urandom_range(0, 99) < prob);
         put(i, {8'(i), 24'(src_seq[i])}, src_pos[i] == src_len[i] - 1);
      end
   endtask

   task automatic advance(input int minlen, input int maxlen);
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            src_seq[i]++;
            src_pos[i]++;
            if (src_pos[i] == src_len[i]) begin
               src_pos[i] = 0;
               src_len[i] = $urandom_range(minlen, maxlen);
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n  = 1'b0;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      m_tready = 1'b1;
      model_reset();
      for (int i = 0; i < N; i++) src_seq[i] = 0;
      @(negedge clk);
      step();
      step();
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_tdata", 64'(m_tdata), 64'd0);
      chk("rst_tlast", 64'(m_tlast), 64'd0);
      chk("rst_tid", 64'(m_tid), 64'd0);
      chk("rst_tready", 64'(s_tready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      reset_n = 1'b1;

      // Single source, 3-beat packet from src1.
      s_tvalid = 4'b0010; put(1, 32'hA1, 0);
      step();
      chk("t1_grant", 64'(s_tready), 64'b0010);
      chk("t1_notyet", 64'(m_tvalid), 64'd0);
      step();
      chk("t1_b1", 64'({m_tvalid, m_tid, m_tdata}), {31'd0, 1'b1, 2'd1, 32'hA1});
      put(1, 32'hA2, 0);
      step();
      chk("t1_b2", 64'(m_tdata), 64'hA2);
      put(1, 32'hA3, 1);
      step();
      chk("t1_b3", 64'({m_tlast, m_tdata}), {31'd0, 1'b1, 32'hA3});
      chk("t1_idle", 64'(busy), 64'd0);
      s_tvalid = '0;
      step();
      chk("t1_drop", 64'(m_tvalid), 64'd0);

      // Backpressure on beat 0xB2 from src0.
      s_tvalid = 4'b0001; put(0, 32'hB1, 0);
      step();
      step();
      put(0, 32'hB2, 0);
      step();
      chk("bp_b2", 64'(m_tdata), 64'hB2);
      put(0, 32'hB3, 1);
      m_tready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("bp_hold", 64'({m_tvalid, m_tlast, m_tid, m_tdata}), {29'd0, 1'b1, 1'b0, 2'd0, 32'hB2});
         chk("bp_tready", 64'(s_tready), 64'd0);
      end
      m_tready = 1'b1;
      step();
      chk("bp_b3", 64'({m_tlast, m_tdata}), {31'd0, 1'b1, 32'hB3});
      s_tvalid = '0;
      step();

      // No interleave with a gap on src2, then a reset mid-packet on src3.
      s_tvalid = 4'b0100; put(2, 32'hC1, 0);
      step();
      step();
      put(2, 32'hC2, 0); put(0, 32'hE1, 0); put(3, 32'hD1, 0);
      s_tvalid = 4'b1101;
      step();
      chk("ni_lock", 64'(s_tready), 64'b0100);
      s_tvalid = 4'b1001;
      step();
      chk("gap_ready", 64'(s_tready), 64'b0100);
      step();
      chk("gap_bubble", 64'({busy, m_tvalid}), 64'b10);
      put(2, 32'hC3, 1);
      s_tvalid = 4'b1101;
      step();
      chk("ni_last", 64'({m_tlast, m_tid, m_tdata}), {29'd0, 1'b1, 2'd2, 32'hC3});
      chk("ni_arbcyc", 64'(s_tready), 64'd0);
      s_tvalid = 4'b1001;
      step();
      chk("ni_next3", 64'(s_tready), 64'b1000);
      step();
      chk("ni_d1", 64'({m_tid, m_tdata}), {30'd0, 2'd3, 32'hD1});
      reset_n = 1'b0;
      step();
      chk("mr_out", 64'({m_tvalid, m_tlast, m_tid, m_tdata}), 64'd0);
      chk("mr_ctl", 64'({busy, s_tready}), 64'd0);
      reset_n = 1'b1;
      s_tvalid = 4'b1111;
      step();
      chk("mr_src0", 64'(s_tready), 64'b0001);

      // Fairness: everyone streams 2-beat packets.
      reset_n = 1'b0;
      s_tvalid = '0;
      step();
      reset_n = 1'b1;
      src_init(2, 2);
      for (int c = 0; c < 20; c++) begin
         drive_sources(100);
         step();
         advance(2, 2);
         if (m_tvalid && m_tlast) tid_q.push_back(int'(m_tid));
      end
      chk("fair_count", 64'(tid_q.size() >= 5), 64'd1);
      if (tid_q.size() >= 5) begin
         chk("fair_order", {tid_q[0][7:0], tid_q[1][7:0], tid_q[2][7:0], tid_q[3][7:0], tid_q[4][7:0]},
             {8'd0, 8'd1, 8'd2, 8'd3, 8'd0});
      end

      // Randomized traffic, backpressure and occasional resets.
      src_init(1, 4);
      for (int c = 0; c < 3000; c++) begin
         reset_n  = ($urandom_range(0, 399) != 0);
         m_tready = ($urandom_range(0, 3) != 0);
         drive_sources(70);
         step();
         advance(1, 4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
